// File: rtl/freq_meter.sv
// ============================================================================
// Module   : freq_meter
// Purpose  : Gated frequency counter. Counts sig_in rising edges over a fixed
//            window of mclk cycles and hands the count over with valid/ack.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module freq_meter #(
  parameter int GATE_CYCLES = 100000000,
  parameter int CNT_W       = 32
) (
  input  logic             mclk,
  input  logic             clr_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             abort,
  input  logic             ack,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             valid,
  output logic             ovf
);

  localparam int                c_GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [c_GATE_W-1:0] c_GATE_LAST = c_GATE_W'(GATE_CYCLES - 1);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_MEASURE = 2'd1;
  localparam logic [1:0] c_DONE    = 2'd2;

  logic [1:0]          r_state;
  logic                r_s1, r_s2, r_s3;
  logic [c_GATE_W-1:0] r_gate_cnt;
  logic [CNT_W-1:0]    r_edge_cnt;
  logic                r_ovf_int;

  logic                w_edge;
  logic [CNT_W-1:0]    w_edge_next;
  logic                w_ovf_next;

  // Two-flop synchroniser plus one delay flop for rising-edge detection.
  always_ff @(posedge mclk or negedge clr_n) begin
    if (!clr_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge = r_s2 & ~r_s3;

  // Saturating count; an edge arriving at all-ones latches the overflow flag.
  always_comb begin
    w_edge_next = r_edge_cnt;
    w_ovf_next  = r_ovf_int;
    if (w_edge) begin
      if (&r_edge_cnt) w_ovf_next  = 1'b1;
      else             w_edge_next = r_edge_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge mclk or negedge clr_n) begin
    if (!clr_n) begin
      r_state    <= c_IDLE;
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_ovf_int  <= 1'b0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      result     <= '0;
      ovf        <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_state    <= c_MEASURE;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_int  <= 1'b0;
            busy       <= 1'b1;
          end
        end
        c_MEASURE: begin
          // Abort wins even on the final window cycle.
          if (abort) begin
            r_state <= c_IDLE;
            busy    <= 1'b0;
          end else begin
            r_gate_cnt <= r_gate_cnt + c_GATE_W'(1);
            r_edge_cnt <= w_edge_next;
            r_ovf_int  <= w_ovf_next;
            if (r_gate_cnt == c_GATE_LAST) begin
              result  <= w_edge_next;
              ovf     <= w_ovf_next;
              valid   <= 1'b1;
              busy    <= 1'b0;
              r_state <= c_DONE;
            end
          end
        end
        c_DONE: begin
          if (ack) begin
            valid   <= 1'b0;
            r_state <= c_IDLE;
          end
        end
        default: begin
          r_state <= c_IDLE;
          busy    <= 1'b0;
          valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_freq_meter.sv
// ============================================================================
// Module   : tb_freq_meter
// Purpose  : Self-checking bench for freq_meter (32-bit and 4-bit counters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_freq_meter;

  localparam int c_GATE = 100;

  logic        mclk   = 1'b0;
  logic        clr_n  = 1'b0;
  logic        sig_in = 1'b0;
  logic        start  = 1'b0;
  logic        abort  = 1'b0;
  logic        ack    = 1'b0;
  logic        busy, valid, ovf;
  logic [31:0] result;
  logic        busy4, valid4, ovf4;
  logic [3:0]  result4;

  freq_meter #(.GATE_CYCLES(c_GATE), .CNT_W(32)) dut (
    .mclk(mclk), .clr_n(clr_n), .sig_in(sig_in), .start(start), .abort(abort),
    .ack(ack), .busy(busy), .result(result), .valid(valid), .ovf(ovf)
  );

  freq_meter #(.GATE_CYCLES(c_GATE), .CNT_W(4)) dut4 (
    .mclk(mclk), .clr_n(clr_n), .sig_in(sig_in), .start(start), .abort(abort),
    .ack(ack), .busy(busy4), .result(result4), .valid(valid4), .ovf(ovf4)
  );

  always #5 mclk = ~mclk;

  // Square-wave source; period in mclk cycles, 0 holds the input low.
  int period = 0;
  int ph     = 0;
  always @(negedge mclk) begin
    if (period == 0) begin
      sig_in = 1'b0;
    end else begin
      ph = ph + 1;
      if (ph >= period) ph = 0;
      sig_in = (ph < period / 2);
    end
  end

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic [3:0]  res4;
    logic        ovf4;
  } exp_t;

  typedef struct {
    int   period;
    exp_t e;
  } vec_t;

  exp_t sb[$];
  exp_t last_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"},    busy,    0);
    check({tag, "_valid"},   valid,   0);
    check({tag, "_ovf"},     ovf,     0);
    check({tag, "_result"},  result,  0);
    check({tag, "_busy4"},   busy4,   0);
    check({tag, "_valid4"},  valid4,  0);
    check({tag, "_ovf4"},    ovf4,    0);
    check({tag, "_result4"}, result4, 0);
  endtask

  // Runs one window; mid_start > 0 pulses start on that busy cycle.
  task automatic measure(input int p, input exp_t e, input int mid_start);
    int   n;
    exp_t got;
    period = p;
    repeat (3) @(negedge mclk);
    sb.push_back(e);
    start = 1'b1;
    @(negedge mclk);
    start = 1'b0;
    check("busy_rise", busy, 1);
    check("valid_low_in_window", valid, 0);
    n = 0;
    while (busy && n < 200) begin
      n++;
      start = (n == mid_start);
      @(negedge mclk);
      start = 1'b0;
    end
    check("window_len", n, c_GATE);
    check("valid_set", valid, 1);
    check("valid4_set", valid4, 1);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      got = sb.pop_front();
      check("result",  result,  got.res);
      check("ovf",     ovf,     got.ovf);
      check("result4", result4, got.res4);
      check("ovf4",    ovf4,    got.ovf4);
      last_e = got;
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge mclk);
    ack = 1'b0;
    check("ack_valid_clear", valid, 0);
    check("ack_busy", busy, 0);
    check("ack_result_kept", result, last_e.res);
  endtask

  initial begin
    vec_t vecs[6];
    exp_t e10;
    e10 = '{res: 32'd10, ovf: 1'b0, res4: 4'd10, ovf4: 1'b0};
    vecs[0] = '{period: 0,  e: '{res: 32'd0,  ovf: 1'b0, res4: 4'd0,  ovf4: 1'b0}};
    vecs[1] = '{period: 10, e: e10};
    vecs[2] = '{period: 10, e: e10};
    vecs[3] = '{period: 10, e: e10};
    vecs[4] = '{period: 2,  e: '{res: 32'd50, ovf: 1'b0, res4: 4'd15, ovf4: 1'b1}};
    vecs[5] = '{period: 10, e: e10};
    last_e = '{res: 32'd0, ovf: 1'b0, res4: 4'd0, ovf4: 1'b0};

    repeat (2) @(negedge mclk);
    check_zero_outputs("reset");
    clr_n = 1'b1;
    @(negedge mclk);

    for (int i = 0; i < 6; i++) begin
      measure(vecs[i].period, vecs[i].e, 0);
      do_ack();
    end

    // Abort around cycle 40 of the window.
    period = 10;
    repeat (3) @(negedge mclk);
    start = 1'b1;
    @(negedge mclk);
    start = 1'b0;
    repeat (39) @(negedge mclk);
    abort = 1'b1;
    @(negedge mclk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    check("abort_result_kept", result, last_e.res);
    repeat (5) @(negedge mclk);
    check("abort_idle_busy", busy, 0);
    check("abort_idle_valid", valid, 0);
    measure(10, e10, 0);
    do_ack();

    // Start while measuring and while done, abort while done, start with ack.
    measure(10, e10, 20);
    start = 1'b1;
    @(negedge mclk);
    start = 1'b0;
    check("done_start_valid", valid, 1);
    check("done_start_busy", busy, 0);
    abort = 1'b1;
    @(negedge mclk);
    abort = 1'b0;
    check("done_abort_valid", valid, 1);
    ack   = 1'b1;
    start = 1'b1;
    @(negedge mclk);
    ack   = 1'b0;
    start = 1'b0;
    check("ack_start_valid", valid, 0);
    check("ack_start_busy", busy, 0);
    @(negedge mclk);
    check("ack_start_no_window", busy, 0);
    measure(10, e10, 0);
    do_ack();

    // Short asynchronous reset pulse in the middle of a window.
    period = 10;
    repeat (3) @(negedge mclk);
    start = 1'b1;
    @(negedge mclk);
    start = 1'b0;
    repeat (30) @(negedge mclk);
    check("pre_reset_busy", busy, 1);
    #1 clr_n = 1'b0;
    #1 check_zero_outputs("async_reset");
    #2 clr_n = 1'b1;
    sb.delete();
    last_e = '{res: 32'd0, ovf: 1'b0, res4: 4'd0, ovf4: 1'b0};
    repeat (3) @(negedge mclk);
    check("post_reset_idle", busy, 0);
    check("post_reset_valid", valid, 0);
    measure(10, e10, 0);
    do_ack();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
